// File: rtl/axi_chan_fifo_bridge.sv
// AXI4+ATOP channel decoupler: one independent FIFO per AW/W/AR/B/R channel, minimum latency 1 cycle.
// Ready = !full and valid = !empty, both register-derived; a stalled head beat is held stable.
module axi_chan_fifo_bridge_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             push_vld,
  output logic             push_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             pop_vld,
  input  logic             pop_rdy
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr, rd_ptr;
  logic               in_reset;
  logic               full, empty, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                 (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);

  // in_reset keeps both handshake sides quiet for the cycle after a sampled reset.
  assign push_rdy = !in_reset && !full;
  assign pop_vld  = !in_reset && !empty;
  assign pop_dat  = pop_vld ? mem[rd_ptr[LOG_DEPTH-1:0]] : '0;

  assign push = push_vld && push_rdy;
  assign pop  = pop_vld && pop_rdy;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_reset <= 1'b1;
    end else begin
      in_reset <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately not reset; only the pointers decide what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[LOG_DEPTH-1:0]] <= push_dat;
  end
endmodule

module axi_chan_fifo_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 2,
  parameter int LOG_DEPTH      = 2,
  localparam int AWB = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 35,
  localparam int WB  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1 + AXI_USER_WIDTH,
  localparam int ARB = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 29,
  localparam int BB  = AXI_ID_WIDTH + AXI_USER_WIDTH + 2,
  localparam int RB  = AXI_ID_WIDTH + AXI_DATA_WIDTH + AXI_USER_WIDTH + 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [AWB-1:0] slv_aw_i,
  input  logic           slv_aw_valid_i,
  output logic           slv_aw_ready_o,
  input  logic [WB-1:0]  slv_w_i,
  input  logic           slv_w_valid_i,
  output logic           slv_w_ready_o,
  input  logic [ARB-1:0] slv_ar_i,
  input  logic           slv_ar_valid_i,
  output logic           slv_ar_ready_o,
  output logic [BB-1:0]  slv_b_o,
  output logic           slv_b_valid_o,
  input  logic           slv_b_ready_i,
  output logic [RB-1:0]  slv_r_o,
  output logic           slv_r_valid_o,
  input  logic           slv_r_ready_i,
  output logic [AWB-1:0] mst_aw_o,
  output logic           mst_aw_valid_o,
  input  logic           mst_aw_ready_i,
  output logic [WB-1:0]  mst_w_o,
  output logic           mst_w_valid_o,
  input  logic           mst_w_ready_i,
  output logic [ARB-1:0] mst_ar_o,
  output logic           mst_ar_valid_o,
  input  logic           mst_ar_ready_i,
  input  logic [BB-1:0]  mst_b_i,
  input  logic           mst_b_valid_i,
  output logic           mst_b_ready_o,
  input  logic [RB-1:0]  mst_r_i,
  input  logic           mst_r_valid_i,
  output logic           mst_r_ready_o
);
  axi_chan_fifo_bridge_fifo #(.WIDTH(AWB), .LOG_DEPTH(LOG_DEPTH)) i_aw_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_dat(slv_aw_i), .push_vld(slv_aw_valid_i), .push_rdy(slv_aw_ready_o),
    .pop_dat(mst_aw_o), .pop_vld(mst_aw_valid_o), .pop_rdy(mst_aw_ready_i)
  );

  axi_chan_fifo_bridge_fifo #(.WIDTH(WB), .LOG_DEPTH(LOG_DEPTH)) i_w_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_dat(slv_w_i), .push_vld(slv_w_valid_i), .push_rdy(slv_w_ready_o),
    .pop_dat(mst_w_o), .pop_vld(mst_w_valid_o), .pop_rdy(mst_w_ready_i)
  );

  axi_chan_fifo_bridge_fifo #(.WIDTH(ARB), .LOG_DEPTH(LOG_DEPTH)) i_ar_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_dat(slv_ar_i), .push_vld(slv_ar_valid_i), .push_rdy(slv_ar_ready_o),
    .pop_dat(mst_ar_o), .pop_vld(mst_ar_valid_o), .pop_rdy(mst_ar_ready_i)
  );

  // Response channels run the other way: downstream pushes, upstream pops.
  axi_chan_fifo_bridge_fifo #(.WIDTH(BB), .LOG_DEPTH(LOG_DEPTH)) i_b_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_dat(mst_b_i), .push_vld(mst_b_valid_i), .push_rdy(mst_b_ready_o),
    .pop_dat(slv_b_o), .pop_vld(slv_b_valid_o), .pop_rdy(slv_b_ready_i)
  );

  axi_chan_fifo_bridge_fifo #(.WIDTH(RB), .LOG_DEPTH(LOG_DEPTH)) i_r_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_dat(mst_r_i), .push_vld(mst_r_valid_i), .push_rdy(mst_r_ready_o),
    .pop_dat(slv_r_o), .pop_vld(slv_r_valid_o), .pop_rdy(slv_r_ready_i)
  );
endmodule

// File: tb/tb_axi_chan_fifo_bridge.sv
// Directed bench for axi_chan_fifo_bridge: per-scenario tasks plus a scoreboarded random phase.
module tb_axi_chan_fifo_bridge;
  localparam int AWB = 73;
  localparam int WB  = 75;
  localparam int ARB = 67;
  localparam int BB  = 8;
  localparam int RB  = 73;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_ni;
  logic [AWB-1:0] slv_aw_i, mst_aw_o;
  logic [WB-1:0]  slv_w_i, mst_w_o;
  logic [ARB-1:0] slv_ar_i, mst_ar_o;
  logic [BB-1:0]  slv_b_o, mst_b_i;
  logic [RB-1:0]  slv_r_o, mst_r_i;
  logic slv_aw_valid_i, slv_aw_ready_o, slv_w_valid_i, slv_w_ready_o, slv_ar_valid_i, slv_ar_ready_o;
  logic slv_b_valid_o, slv_b_ready_i, slv_r_valid_o, slv_r_ready_i;
  logic mst_aw_valid_o, mst_aw_ready_i, mst_w_valid_o, mst_w_ready_i, mst_ar_valid_o, mst_ar_ready_i;
  logic mst_b_valid_i, mst_b_ready_o, mst_r_valid_i, mst_r_ready_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [74:0] exp_q [5][$];

  axi_chan_fifo_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slv_aw_i(slv_aw_i), .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_w_i(slv_w_i), .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
    .slv_ar_i(slv_ar_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_b_o(slv_b_o), .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
    .slv_r_o(slv_r_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
    .mst_aw_o(mst_aw_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_o(mst_w_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_ar_o(mst_ar_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_b_i(mst_b_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
    .mst_r_i(mst_r_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    slv_aw_i = '0; slv_w_i = '0; slv_ar_i = '0; mst_b_i = '0; mst_r_i = '0;
    slv_aw_valid_i = 0; slv_w_valid_i = 0; slv_ar_valid_i = 0; mst_b_valid_i = 0; mst_r_valid_i = 0;
    slv_b_ready_i = 0; slv_r_ready_i = 0; mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_ar_ready_i = 0;
    step(); step();
    n_cmp++; if ({slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o, mst_b_ready_o, mst_r_ready_o} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00000", {slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o, mst_b_ready_o, mst_r_ready_o}); end
    n_cmp++; if ({mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_valid: got %b want 00000", {mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o}); end
    n_cmp++; if ({mst_aw_o, mst_w_o, mst_ar_o, slv_b_o, slv_r_o} !== 296'b0) begin
      n_fail++; $display("FAIL reset_payload: payload outputs not all zero"); end
    rst_ni = 1'b1;
    step();
    n_cmp++; if ({slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o, mst_b_ready_o, mst_r_ready_o} !== 5'b11111) begin
      n_fail++; $display("FAIL release_ready: got %b want 11111", {slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o, mst_b_ready_o, mst_r_ready_o}); end
    n_cmp++; if ({mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o} !== 5'b00000) begin
      n_fail++; $display("FAIL release_valid: got %b want 00000", {mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o}); end
  endtask

  task automatic test_aw_single();
    logic [AWB-1:0] aw;
    aw = {4'd3, 32'h0000_1000, 8'd0, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 6'h0, 2'b11};
    mst_aw_ready_i = 1'b1;
    slv_aw_i = aw; slv_aw_valid_i = 1'b1;
    n_cmp++; if (slv_aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL aw_ready: got %b want 1", slv_aw_ready_o); end
    n_cmp++; if (mst_aw_valid_o !== 1'b0) begin n_fail++; $display("FAIL aw_no_fallthrough: got %b want 0", mst_aw_valid_o); end
    step();
    slv_aw_valid_i = 1'b0; slv_aw_i = '0;
    n_cmp++; if (mst_aw_valid_o !== 1'b1) begin n_fail++; $display("FAIL aw_valid_next: got %b want 1", mst_aw_valid_o); end
    n_cmp++; if (mst_aw_o !== aw) begin n_fail++; $display("FAIL aw_payload: got %h want %h", mst_aw_o, aw); end
    step();
    n_cmp++; if (mst_aw_valid_o !== 1'b0) begin n_fail++; $display("FAIL aw_drained: got %b want 0", mst_aw_valid_o); end
    mst_aw_ready_i = 1'b0;
  endtask

  task automatic test_w_full();
    logic [WB-1:0] w_beats [6];
    int acc = 0;
    bit hs;
    for (int k = 0; k < 6; k++)
      w_beats[k] = {64'h1111_2222_0000_0000 + 64'(k), 8'hFF >> k, (k == 3), 2'(k)};
    mst_w_ready_i = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      slv_w_i = w_beats[(acc > 5) ? 5 : acc];
      slv_w_valid_i = 1'b1;
      hs = slv_w_ready_o;
      step();
      if (hs) acc++;
    end
    slv_w_valid_i = 1'b0; slv_w_i = '0;
    n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL w_accept_count: got %0d want 4", acc); end
    n_cmp++; if (slv_w_ready_o !== 1'b0) begin n_fail++; $display("FAIL w_full_ready: got %b want 0", slv_w_ready_o); end
    mst_w_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mst_w_valid_o !== 1'b1 || mst_w_o !== w_beats[k]) begin
        n_fail++; $display("FAIL w_drain_%0d: got v=%b %h want v=1 %h", k, mst_w_valid_o, mst_w_o, w_beats[k]); end
      step();
    end
    n_cmp++; if (mst_w_valid_o !== 1'b0) begin n_fail++; $display("FAIL w_empty: got %b want 0", mst_w_valid_o); end
    mst_w_ready_i = 1'b0;
  endtask

  task automatic test_ar_steady();
    logic [ARB-1:0] ar_beats [102];
    logic [95:0] rnd;
    for (int k = 0; k < 102; k++) begin
      rnd = {$urandom, $urandom, $urandom};
      ar_beats[k] = rnd[ARB-1:0];
    end
    mst_ar_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      slv_ar_i = ar_beats[k]; slv_ar_valid_i = 1'b1;
      step();
    end
    mst_ar_ready_i = 1'b1;
    for (int k = 2; k < 102; k++) begin
      slv_ar_i = ar_beats[k];
      n_cmp++; if (slv_ar_ready_o !== 1'b1 || mst_ar_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL ar_steady_hs_%0d: got rdy=%b vld=%b want 1 1", k, slv_ar_ready_o, mst_ar_valid_o); end
      n_cmp++; if (mst_ar_o !== ar_beats[k-2]) begin
        n_fail++; $display("FAIL ar_steady_order_%0d: got %h want %h", k, mst_ar_o, ar_beats[k-2]); end
      step();
    end
    slv_ar_valid_i = 1'b0; slv_ar_i = '0;
    for (int k = 100; k < 102; k++) begin
      n_cmp++; if (mst_ar_valid_o !== 1'b1 || mst_ar_o !== ar_beats[k]) begin
        n_fail++; $display("FAIL ar_tail_%0d: got v=%b %h want v=1 %h", k, mst_ar_valid_o, mst_ar_o, ar_beats[k]); end
      step();
    end
    n_cmp++; if (mst_ar_valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_empty: got %b want 0", mst_ar_valid_o); end
    mst_ar_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [RB-1:0] r_beats [16];
    int got = 0;
    for (int i = 0; i < 16; i++)
      r_beats[i] = {4'(i), 32'hCAFE_0000 | 32'(i), 32'(i * 7), 2'b00, (i == 15), 2'b10};
    fork
      begin
        bit hs;
        for (int i = 0; i < 16; i++) begin
          mst_r_i = r_beats[i]; mst_r_valid_i = 1'b1;
          for (int t = 0; t < 200; t++) begin
            hs = mst_r_ready_o;
            step();
            if (hs) break;
          end
        end
        mst_r_valid_i = 1'b0; mst_r_i = '0;
      end
      begin
        bit rdy;
        for (int t = 0; t < 2000 && got < 16; t++) begin
          rdy = 1'($urandom_range(0, 1));
          slv_r_ready_i = rdy;
          if (rdy && slv_r_valid_o === 1'b1) begin
            n_cmp++; if (slv_r_o !== r_beats[got]) begin
              n_fail++; $display("FAIL r_stream_%0d: got %h want %h", got, slv_r_o, r_beats[got]); end
            n_cmp++; if (slv_r_o[2] !== (got == 15)) begin
              n_fail++; $display("FAIL r_last_%0d: got %b want %b", got, slv_r_o[2], (got == 15)); end
            got++;
          end
          step();
        end
        slv_r_ready_i = 1'b0;
      end
    join
    n_cmp++; if (got != 16) begin n_fail++; $display("FAIL r_stream_count: got %0d want 16", got); end
  endtask

  task automatic test_reset_mid();
    slv_b_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mst_b_i = 8'hA0 + 8'(i); mst_b_valid_i = 1'b1;
      step();
    end
    mst_b_valid_i = 1'b0; mst_b_i = '0;
    n_cmp++; if (slv_b_valid_o !== 1'b1 || slv_b_o !== 8'hA0) begin
      n_fail++; $display("FAIL b_stored: got v=%b %h want v=1 a0", slv_b_valid_o, slv_b_o); end
    rst_ni = 1'b0;
    step();
    n_cmp++; if (slv_b_valid_o !== 1'b0 || mst_b_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b_in_reset: got v=%b rdy=%b want 0 0", slv_b_valid_o, mst_b_ready_o); end
    rst_ni = 1'b1;
    step();
    n_cmp++; if (mst_b_ready_o !== 1'b1) begin n_fail++; $display("FAIL b_ready_back: got %b want 1", mst_b_ready_o); end
    slv_b_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (slv_b_valid_o !== 1'b0) begin n_fail++; $display("FAIL b_discarded_%0d: got %b want 0", i, slv_b_valid_o); end
      step();
    end
    mst_b_i = 8'h5A; mst_b_valid_i = 1'b1;
    step();
    mst_b_valid_i = 1'b0; mst_b_i = '0;
    n_cmp++; if (slv_b_valid_o !== 1'b1 || slv_b_o !== 8'h5A) begin
      n_fail++; $display("FAIL b_after_reset: got v=%b %h want v=1 5a", slv_b_valid_o, slv_b_o); end
    step();
    slv_b_ready_i = 1'b0;
  endtask

  // Channel order: 0 AW, 1 W, 2 AR (upstream sources), 3 B, 4 R (downstream sources).
  task automatic test_random();
    int cw [5] = '{AWB, WB, ARB, BB, RB};
    int total [5] = '{500, 500, 500, 500, 500};
    int sent [5], sstall [5], kstall [5], bcnt [5], blen [5];
    bit sv [5], kr [5], srdy [5], dvld [5];
    logic [74:0] sdat [5], ddat [5], mask, expv;
    logic [95:0] rnd;
    int cyc = 0;
    bit busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sent[c] = 0; sstall[c] = 0; kstall[c] = 0; bcnt[c] = 0; blen[c] = 1; sv[c] = 0; sdat[c] = '0;
      exp_q[c].delete();
    end
    while (busy && cyc < 60000) begin
      srdy = '{slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o, mst_b_ready_o, mst_r_ready_o};
      dvld = '{mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o};
      ddat[0] = {2'b0, mst_aw_o}; ddat[1] = mst_w_o; ddat[2] = {8'b0, mst_ar_o};
      ddat[3] = {67'b0, slv_b_o}; ddat[4] = {2'b0, slv_r_o};
      for (int c = 0; c < 5; c++) begin
        if (!sv[c] && sent[c] < total[c]) begin
          if (sstall[c] == 0) begin
            rnd = {$urandom, $urandom, $urandom};
            mask = {75{1'b1}} >> (75 - cw[c]);
            sdat[c] = rnd[74:0] & mask;
            if (c == 1 || c == 4) begin
              if (bcnt[c] == 0) blen[c] = $urandom_range(1, 16);
              sdat[c][2] = (bcnt[c] == blen[c] - 1);
              bcnt[c] = sdat[c][2] ? 0 : bcnt[c] + 1;
            end
            sv[c] = 1'b1;
          end else sstall[c]--;
        end
        kr[c] = (kstall[c] == 0);
        if (!kr[c]) kstall[c]--;
      end
      slv_aw_i = sdat[0][AWB-1:0]; slv_aw_valid_i = sv[0]; mst_aw_ready_i = kr[0];
      slv_w_i  = sdat[1][WB-1:0];  slv_w_valid_i  = sv[1]; mst_w_ready_i  = kr[1];
      slv_ar_i = sdat[2][ARB-1:0]; slv_ar_valid_i = sv[2]; mst_ar_ready_i = kr[2];
      mst_b_i  = sdat[3][BB-1:0];  mst_b_valid_i  = sv[3]; slv_b_ready_i  = kr[3];
      mst_r_i  = sdat[4][RB-1:0];  mst_r_valid_i  = sv[4]; slv_r_ready_i  = kr[4];
      for (int c = 0; c < 5; c++) begin
        if (kr[c] && dvld[c]) begin
          n_cmp++;
          if (exp_q[c].size() == 0) begin
            n_fail++; $display("FAIL rand_ch%0d_extra: got %h want no beat", c, ddat[c]);
          end else begin
            expv = exp_q[c].pop_front();
            if (ddat[c] !== expv) begin n_fail++; $display("FAIL rand_ch%0d_data: got %h want %h", c, ddat[c], expv); end
          end
          kstall[c] = $urandom_range(0, 10);
        end
        if (sv[c] && srdy[c]) begin
          exp_q[c].push_back(sdat[c]);
          if (!(c == 1 || c == 4) || sdat[c][2]) sent[c]++;
          sv[c] = 1'b0;
          sstall[c] = $urandom_range(0, 10);
        end
      end
      busy = 1'b0;
      for (int c = 0; c < 5; c++)
        if (sent[c] < total[c] || sv[c] || exp_q[c].size() != 0) busy = 1'b1;
      step();
      cyc++;
    end
    slv_aw_valid_i = 0; slv_w_valid_i = 0; slv_ar_valid_i = 0; mst_b_valid_i = 0; mst_r_valid_i = 0;
    mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_ar_ready_i = 0; slv_b_ready_i = 0; slv_r_ready_i = 0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (sent[c] != total[c] || exp_q[c].size() != 0) begin
        n_fail++; $display("FAIL rand_ch%0d_complete: got sent=%0d pending=%0d want sent=%0d pending=0",
                           c, sent[c], exp_q[c].size(), total[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_aw_single();
    test_w_full();
    test_ar_steady();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
